// File: rtl/mac_accumulator.sv
// mac_accumulator: dot-product accumulator for one output channel.
//
// Streams LEN signed int8 activation/weight pairs. Each accepted pair is multiplied in a
// one-cycle product stage. The products are summed on top of a 32-bit bias, which is
// loaded on the first beat of each window. The signed 32-bit result is offered downstream
// with a valid/ready handshake.
//
// Optional build macro: MAC_ACCUMULATOR_SAT_EN
//   defined   - every accumulate addition saturates to the int32 range, and ovf flags a clamp
//   undefined - additions wrap two's-complement, and ovf is tied to 0
//
// Ports:
//   clk        clock, rising edge
//   rst_b      synchronous reset, active-high (1 = reset)
//   in_valid   act/wgt/bias valid
//   in_ready   block accepts a beat this cycle
//   act, wgt   signed 8-bit operands
//   bias       signed 32-bit bias, sampled only on the first beat of a window
//   out_valid  data_out holds a finished sum
//   out_ready  downstream accepts the sum
//   data_out   signed 32-bit accumulator value
//   ovf        saturation occurred in the current window
module mac_accumulator #(
    parameter int unsigned LEN   = 25,
    parameter int unsigned CNT_W = 10
) (
    input  logic               clk,
    input  logic               rst_b,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic signed [7:0]  act,
    input  logic signed [7:0]  wgt,
    input  logic signed [31:0] bias,
    output logic               out_valid,
    input  logic               out_ready,
    output logic signed [31:0] data_out,
    output logic               ovf
);

    typedef enum logic [1:0] {StAccum, StDrain, StHold} state_e;

    localparam logic [CNT_W-1:0] LastCount = CNT_W'(LEN - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic signed [31:0] acc_q, acc_d;
    logic signed [15:0] p_q, p_d;
    logic               p_vld_q, p_vld_d;
    logic               accept;
    logic               first_beat;
    logic signed [31:0] p_ext;

`ifdef MAC_ACCUMULATOR_SAT_EN
    logic               ovf_q, ovf_d;
    logic [32:0]        sum_wide;
`endif

    assign in_ready   = (state_q == StAccum);
    assign out_valid  = (state_q == StHold);
    assign data_out   = acc_q;
    assign accept     = in_valid && in_ready;
    assign first_beat = accept && (count_q == '0);
    assign p_ext      = {{16{p_q[15]}}, p_q};

    // Product stage. The 8x8 signed product fits in 16 bits. The low 16 bits of the
    // sign-extended multiply are therefore exact.
    always_comb begin
        p_d     = p_q;
        p_vld_d = accept;
        if (accept) begin
            p_d = $signed({{8{act[7]}}, act}) * $signed({{8{wgt[7]}}, wgt});
        end
    end

    // Window counter and control FSM.
    always_comb begin
        count_d = count_q;
        state_d = state_q;
        unique case (state_q)
            StAccum: begin
                if (accept) begin
                    if (count_q == LastCount) begin
                        count_d = '0;
                        state_d = StDrain;
                    end else begin
                        count_d = count_q + CNT_W'(1);
                    end
                end
            end
            // The last product lands in acc on this edge.
            StDrain: state_d = StHold;
            StHold: begin
                if (out_ready) begin
                    state_d = StAccum;
                end
            end
            default: state_d = StAccum;
        endcase
    end

    // Accumulator. The bias load on the first beat never collides with a pending product,
    // because the drain state empties the pipeline before the next window can start.
    always_comb begin
        acc_d = acc_q;
`ifdef MAC_ACCUMULATOR_SAT_EN
        ovf_d    = ovf_q;
        sum_wide = {acc_q[31], acc_q} + {p_ext[31], p_ext};
        if (p_vld_q) begin
            if (sum_wide[32] != sum_wide[31]) begin
                acc_d = sum_wide[32] ? 32'sh8000_0000 : 32'sh7fff_ffff;
                ovf_d = 1'b1;
            end else begin
                acc_d = sum_wide[31:0];
            end
        end
        if (first_beat) begin
            acc_d = bias;
            ovf_d = 1'b0;
        end
`else
        if (p_vld_q) begin
            acc_d = acc_q + p_ext;
        end
        if (first_beat) begin
            acc_d = bias;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst_b) begin
            state_q <= StAccum;
            count_q <= '0;
            acc_q   <= '0;
            p_q     <= '0;
            p_vld_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            acc_q   <= acc_d;
            p_q     <= p_d;
            p_vld_q <= p_vld_d;
        end
    end

`ifdef MAC_ACCUMULATOR_SAT_EN
    always_ff @(posedge clk) begin
        if (rst_b) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: doc/mac_accumulator.md
Name: mac_accumulator

Overview:
- Upstream neighbour of the rescale stage: one output channel's dot-product accumulator.
- Streams LEN signed int8 activation/weight pairs and multiplies each pair.
- Adds the products to a 32-bit bias.
- Presents the signed 32-bit sum, with a valid/ready handshake, as the rescale stage's data_in.

Parameters:
- LEN, 25, number of activation/weight pairs per window (kernel size x in-channels); legal range 1..1024.
- CNT_W, 10, counter width; must satisfy 2^CNT_W > LEN.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_b  input  1  reset; synchronous, active-high (1 = reset).
- in_valid  input  1  act/wgt/bias valid.
- in_ready  output  1  block accepts a beat this cycle.
- act  input  8  signed activation.
- wgt  input  8  signed weight.
- bias  input  32  signed bias; sampled only on the first beat of a window.
- out_valid  output  1  data_out holds a finished sum.
- out_ready  input  1  downstream (rescale) accepts the sum.
- data_out  output  32  signed accumulated sum.
- ovf  output  1  saturation occurred in the current window (see Optional Feature).

Behaviour:
- Reset: when rst_b=1 at a clock edge, the following clear regardless of other inputs:
  - state=ACCUM, count=0, acc=0, product register p_vld=0, ovf=0.
  - Resulting outputs: out_valid=0, data_out=0, in_ready=1.
  - Reset mid-window or mid-hold discards the partial sum; no output is produced.
- Beat acceptance: a beat is accepted at an edge iff in_valid && in_ready.
- Product stage (1 cycle):
  - On an accepted beat: p_reg <= act*wgt (signed 16-bit, full precision), p_vld <= 1.
  - Otherwise p_vld <= 0.
- Accumulate stage:
  - At any edge with p_vld=1: acc <= acc + sign-extended p_reg (32-bit).
  - Without the macro, addition wraps modulo 2^32.
- Bias: on the accepted beat with count=0, acc <= bias (overwrite).
  - p_vld is guaranteed 0 at that edge, because the DRAIN state holds off the next window until the pipeline is empty.
- count:
  - Increments on each accepted beat.
  - On the LEN-th accepted beat: count <= 0 and state <= DRAIN.
- States:
  - ACCUM: in_ready=1, out_valid=0.
  - DRAIN: in_ready=0; adds the final product; unconditional -> HOLD next edge.
  - HOLD: in_ready=0, out_valid=1, data_out=acc stable. On out_valid && out_ready -> ACCUM (out_valid falls, in_ready rises the next cycle).
- Latency: last beat accepted at edge E -> out_valid=1 after edge E+1 (2 edges). Minimum window period is LEN+2 cycles.
- in_valid gaps:
  - Allowed anywhere in a window; count holds and acc keeps absorbing in-flight products.
  - act, wgt and bias are ignored when not accepted.
- Output stability: data_out and out_valid must not change while out_valid=1 && out_ready=0.
- data_out is acc at all times; it is only meaningful when out_valid=1.
- LEN=1: each accepted beat yields one output, bias + act*wgt.

Optional Feature:
- Macro: MAC_ACCUMULATOR_SAT_EN.
- Defined:
  - Every accumulate addition saturates to [-2147483648, 2147483647].
  - ovf goes high on the edge a clamp occurs, stays high through HOLD, and clears when the window's first beat is accepted or on reset.
- Undefined:
  - Addition wraps two's-complement.
  - ovf is tied to 0.
  - No saturation logic is synthesised.

Test Plan:
- Basic window (LEN=4): bias=10, act=[1,2,3,4], wgt=[1,1,1,1], in_valid held high -> out_valid two edges after the 4th beat, data_out=20, ovf=0.
- Extreme operands (LEN=25): act=-128, wgt=-128 for all beats, bias=0 -> data_out=409600. Then act=-128, wgt=127, bias=-5 -> data_out=-406405.
- Backpressure (LEN=4):
  - out_ready held 0 for 6 cycles after out_valid -> data_out stable, in_ready=0 throughout.
  - out_ready=1 -> out_valid drops next cycle, in_ready=1.
  - Next window (bias=0, all 1s) -> data_out=4.
- Input gaps (LEN=4): in_valid toggled 1,0,0,1,1,0,1 with act=[5,-3,7,2], wgt=2, bias=0 -> data_out=22; only 4 accepted beats counted.
- Reset mid-window (LEN=4): rst_b=1 for one edge after 2 beats, then a full window with bias=1 and all 1s -> data_out=5; no spurious out_valid.
- Saturation (LEN=1): bias=2147483548, act=127, wgt=1.
  - With MAC_ACCUMULATOR_SAT_EN -> data_out=2147483647, ovf=1.
  - Without the macro -> data_out=-2147483621, ovf=0.
